// File: rtl/axi_wr_burst_sched.sv
// Round-robin burst scheduler sharing one AXI write channel between two DDR ring-buffer streams.
// Define WR_SCHED_WATCHDOG_EN to add the CMD/DATA watchdog and the o_timeout flag.
module axi_wr_burst_sched #(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    DATA_WIDTH      = 64,
    parameter int                    BURST_LEN       = 16,
    parameter int                    LEVEL_WIDTH     = 12,
    parameter logic [ADDR_WIDTH-1:0] CH0_BASE        = 32'h1000_0000,
    parameter logic [ADDR_WIDTH-1:0] CH1_BASE        = 32'h1800_0000,
    parameter logic [ADDR_WIDTH-1:0] BUF_BYTES       = 32'h0080_0000,
    parameter int                    MAX_OUTSTANDING = 4
`ifdef WR_SCHED_WATCHDOG_EN
    ,
    parameter int                    TIMEOUT_CYCLES  = 4096
`endif
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_enable,
    input  logic [LEVEL_WIDTH-1:0] i_ch0_level,
    input  logic [LEVEL_WIDTH-1:0] i_ch1_level,
    output logic                   o_cmd_valid,
    input  logic                   i_cmd_ready,
    output logic [ADDR_WIDTH-1:0]  o_cmd_addr,
    output logic [7:0]             o_cmd_len,
    output logic                   o_cmd_ch,
    input  logic                   i_burst_done,
    input  logic                   i_bvalid,
    input  logic [1:0]             i_bresp,
    output logic                   o_bready,
    output logic [ADDR_WIDTH-1:0]  o_ch0_ptr,
    output logic [ADDR_WIDTH-1:0]  o_ch1_ptr,
    output logic [3:0]             o_outstanding,
    output logic                   o_busy,
    output logic                   o_err,
`ifdef WR_SCHED_WATCHDOG_EN
    output logic                   o_timeout,
`endif
    input  logic                   i_clr_err
);

    localparam int                     BURST_BYTES = BURST_LEN * DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0]  STEP        = ADDR_WIDTH'(BURST_BYTES);
    localparam logic [ADDR_WIDTH-1:0]  CH0_END     = CH0_BASE + BUF_BYTES;
    localparam logic [ADDR_WIDTH-1:0]  CH1_END     = CH1_BASE + BUF_BYTES;
    localparam logic [LEVEL_WIDTH-1:0] LEVEL_MIN   = LEVEL_WIDTH'(BURST_LEN);
    localparam logic [3:0]             MAX_OUT     = 4'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic                    cmd_valid_q, cmd_valid_d;
    logic [ADDR_WIDTH-1:0]   cmd_addr_q, cmd_addr_d;
    logic                    cmd_ch_q, cmd_ch_d;
    logic                    bready_q, bready_d;
    logic [ADDR_WIDTH-1:0]   ch0_ptr_q, ch0_ptr_d;
    logic [ADDR_WIDTH-1:0]   ch1_ptr_q, ch1_ptr_d;
    logic [3:0]              outstanding_q, outstanding_d;
    logic                    err_q, err_d;
    logic                    last_grant_q, last_grant_d;

    logic                    elig0, elig1, issue_ok, grant;
    logic                    cmd_hs, b_acc, b_dec;
    logic [ADDR_WIDTH-1:0]   ptr_inc;

`ifdef WR_SCHED_WATCHDOG_EN
    localparam int           WD_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0]         wd_cnt_q, wd_cnt_d;
    logic                    timeout_q, timeout_d;
    logic                    wd_run;
`endif

    assign elig0    = i_ch0_level >= LEVEL_MIN;
    assign elig1    = i_ch1_level >= LEVEL_MIN;
    assign issue_ok = i_enable && (outstanding_q < MAX_OUT) && (elig0 || elig1);
    // Prefer the channel opposite the last grant; fall back to whichever is eligible.
    assign grant    = last_grant_q ? !elig0 : elig1;
    assign cmd_hs   = (state_q == CMD) && cmd_valid_q && i_cmd_ready;
    assign b_acc    = i_bvalid && bready_q;
    assign b_dec    = b_acc && (outstanding_q != 4'd0);

    always_comb begin
        state_d       = state_q;
        cmd_valid_d   = cmd_valid_q;
        cmd_addr_d    = cmd_addr_q;
        cmd_ch_d      = cmd_ch_q;
        bready_d      = 1'b1;
        ch0_ptr_d     = ch0_ptr_q;
        ch1_ptr_d     = ch1_ptr_q;
        outstanding_d = outstanding_q;
        err_d         = err_q;
        last_grant_d  = last_grant_q;
        ptr_inc       = (cmd_ch_q ? ch1_ptr_q : ch0_ptr_q) + STEP;

        case (state_q)
            IDLE: begin
                if (issue_ok) begin
                    state_d     = CMD;
                    cmd_valid_d = 1'b1;
                    cmd_ch_d    = grant;
                    cmd_addr_d  = grant ? ch1_ptr_q : ch0_ptr_q;
                end
            end
            CMD: begin
                if (i_cmd_ready) begin
                    state_d      = DATA;
                    cmd_valid_d  = 1'b0;
                    last_grant_d = cmd_ch_q;
                    if (cmd_ch_q) begin
                        ch1_ptr_d = (ptr_inc == CH1_END) ? CH1_BASE : ptr_inc;
                    end else begin
                        ch0_ptr_d = (ptr_inc == CH0_END) ? CH0_BASE : ptr_inc;
                    end
                end
            end
            DATA: begin
                if (i_burst_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                cmd_valid_d = 1'b0;
            end
        endcase

        case ({cmd_hs, b_dec})
            2'b10:   outstanding_d = outstanding_q + 4'd1;
            2'b01:   outstanding_d = outstanding_q - 4'd1;
            default: outstanding_d = outstanding_q;
        endcase

        // A response with nothing outstanding is dropped but flagged as an error.
        if (i_clr_err) begin
            err_d = 1'b0;
        end
        if (b_acc && ((i_bresp != 2'b00) || (outstanding_q == 4'd0))) begin
            err_d = 1'b1;
        end
    end

`ifdef WR_SCHED_WATCHDOG_EN
    assign wd_run = (state_q == DATA) || ((state_q == CMD) && !i_cmd_ready);

    always_comb begin
        wd_cnt_d  = '0;
        timeout_d = timeout_q;
        if (i_clr_err) begin
            timeout_d = 1'b0;
        end
        if (wd_run) begin
            if (wd_cnt_q == WD_LAST) begin
                timeout_d = 1'b1;
            end else begin
                wd_cnt_d = wd_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_timeout = timeout_q;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= IDLE;
            cmd_valid_q   <= 1'b0;
            cmd_addr_q    <= '0;
            cmd_ch_q      <= 1'b0;
            bready_q      <= 1'b0;
            ch0_ptr_q     <= CH0_BASE;
            ch1_ptr_q     <= CH1_BASE;
            outstanding_q <= 4'd0;
            err_q         <= 1'b0;
            last_grant_q  <= 1'b1;
        end else begin
`ifdef WR_SCHED_WATCHDOG_EN
            // Expiry abandons the stuck command/burst but keeps pointers and count.
            if (wd_run && (wd_cnt_q == WD_LAST)) begin
                state_q     <= IDLE;
                cmd_valid_q <= 1'b0;
            end else begin
                state_q     <= state_d;
                cmd_valid_q <= cmd_valid_d;
            end
`else
            state_q       <= state_d;
            cmd_valid_q   <= cmd_valid_d;
`endif
            cmd_addr_q    <= cmd_addr_d;
            cmd_ch_q      <= cmd_ch_d;
            bready_q      <= bready_d;
            ch0_ptr_q     <= ch0_ptr_d;
            ch1_ptr_q     <= ch1_ptr_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
            last_grant_q  <= last_grant_d;
        end
    end

    assign o_cmd_valid   = cmd_valid_q;
    assign o_cmd_addr    = cmd_addr_q;
    assign o_cmd_len     = 8'(BURST_LEN - 1);
    assign o_cmd_ch      = cmd_ch_q;
    assign o_bready      = bready_q;
    assign o_ch0_ptr     = ch0_ptr_q;
    assign o_ch1_ptr     = ch1_ptr_q;
    assign o_outstanding = outstanding_q;
    assign o_busy        = (state_q != IDLE) || (outstanding_q != 4'd0);
    assign o_err         = err_q;

endmodule

// File: tb/tb_axi_wr_burst_sched.sv
// Scoreboard bench for axi_wr_burst_sched with a 0x100-byte ring so wrap-around shows up quickly.
// Honours WR_SCHED_WATCHDOG_EN to exercise the watchdog timeout.
module tb_axi_wr_burst_sched;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_enable;
    logic [11:0] i_ch0_level;
    logic [11:0] i_ch1_level;
    logic        o_cmd_valid;
    logic        i_cmd_ready;
    logic [31:0] o_cmd_addr;
    logic [7:0]  o_cmd_len;
    logic        o_cmd_ch;
    logic        i_burst_done;
    logic        i_bvalid;
    logic [1:0]  i_bresp;
    logic        o_bready;
    logic [31:0] o_ch0_ptr;
    logic [31:0] o_ch1_ptr;
    logic [3:0]  o_outstanding;
    logic        o_busy;
    logic        o_err;
    logic        i_clr_err;
`ifdef WR_SCHED_WATCHDOG_EN
    logic        o_timeout;
`endif

    typedef struct {
        logic [31:0] addr;
        logic        ch;
    } cmd_t;

    cmd_t expQ[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cmdSeen     = 0;
    bit   autoDone    = 1'b1;

    axi_wr_burst_sched #(
        .BUF_BYTES(32'h0000_0100)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_enable      (i_enable),
        .i_ch0_level   (i_ch0_level),
        .i_ch1_level   (i_ch1_level),
        .o_cmd_valid   (o_cmd_valid),
        .i_cmd_ready   (i_cmd_ready),
        .o_cmd_addr    (o_cmd_addr),
        .o_cmd_len     (o_cmd_len),
        .o_cmd_ch      (o_cmd_ch),
        .i_burst_done  (i_burst_done),
        .i_bvalid      (i_bvalid),
        .i_bresp       (i_bresp),
        .o_bready      (o_bready),
        .o_ch0_ptr     (o_ch0_ptr),
        .o_ch1_ptr     (o_ch1_ptr),
        .o_outstanding (o_outstanding),
        .o_busy        (o_busy),
        .o_err         (o_err),
`ifdef WR_SCHED_WATCHDOG_EN
        .o_timeout     (o_timeout),
`endif
        .i_clr_err     (i_clr_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int lvl0, input int lvl1, input bit en);
        @(negedge i_clk);
        i_ch0_level = 12'(lvl0);
        i_ch1_level = 12'(lvl1);
        i_enable    = en;
    endtask

    task automatic sendB(input logic [1:0] resp);
        @(negedge i_clk);
        i_bvalid = 1'b1;
        i_bresp  = resp;
        @(negedge i_clk);
        i_bvalid = 1'b0;
        i_bresp  = 2'b00;
    endtask

    task automatic pulseClr();
        @(negedge i_clk);
        i_clr_err = 1'b1;
        @(negedge i_clk);
        i_clr_err = 1'b0;
    endtask

    task automatic waitCmds(input int n);
        for (int i = 0; i < 300 && cmdSeen < n; i++) @(negedge i_clk);
        checkOutput($sformatf("command count reaches %0d", n), cmdSeen, n);
    endtask

    task automatic waitValid();
        for (int i = 0; i < 50 && !o_cmd_valid; i++) @(negedge i_clk);
        checkOutput("cmd valid raised", o_cmd_valid, 1);
    endtask

    task automatic doReset();
        @(negedge i_clk);
        i_rst_n     = 1'b0;
        i_enable    = 1'b0;
        i_ch0_level = '0;
        i_ch1_level = '0;
        i_bvalid    = 1'b0;
        i_bresp     = 2'b00;
        i_clr_err   = 1'b0;
        repeat (2) @(negedge i_clk);
        checkOutput("reset cmd_valid", o_cmd_valid, 0);
        checkOutput("reset cmd_addr", o_cmd_addr, 0);
        checkOutput("reset cmd_len", o_cmd_len, 8'h0F);
        checkOutput("reset cmd_ch", o_cmd_ch, 0);
        checkOutput("reset bready", o_bready, 0);
        checkOutput("reset ch0_ptr", o_ch0_ptr, 32'h1000_0000);
        checkOutput("reset ch1_ptr", o_ch1_ptr, 32'h1800_0000);
        checkOutput("reset outstanding", o_outstanding, 0);
        checkOutput("reset busy", o_busy, 0);
        checkOutput("reset err", o_err, 0);
`ifdef WR_SCHED_WATCHDOG_EN
        checkOutput("reset timeout", o_timeout, 0);
`endif
        i_rst_n = 1'b1;
        @(negedge i_clk);
        checkOutput("bready after reset release", o_bready, 1);
    endtask

    // Engine model: answers each accepted command with a wlast pulse a few cycles later.
    initial begin
        i_burst_done = 1'b0;
        forever begin
            @(negedge i_clk);
            #2;
            if (i_rst_n && o_cmd_valid && i_cmd_ready && autoDone) begin
                @(negedge i_clk);
                @(negedge i_clk);
                i_burst_done = 1'b1;
                @(negedge i_clk);
                i_burst_done = 1'b0;
            end
        end
    end

    // Monitor: every command handshake is checked against the head of the expected queue.
    initial begin
        forever begin
            @(negedge i_clk);
            #2;
            if (i_rst_n && o_cmd_valid && i_cmd_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput($sformatf("unexpected cmd%0d addr", cmdSeen), o_cmd_addr, 32'hFFFF_FFFF);
                end else begin
                    cmd_t e;
                    e = expQ.pop_front();
                    checkOutput($sformatf("cmd%0d addr", cmdSeen), o_cmd_addr, e.addr);
                    checkOutput($sformatf("cmd%0d ch", cmdSeen), o_cmd_ch, e.ch);
                    checkOutput($sformatf("cmd%0d len", cmdSeen), o_cmd_len, 8'h0F);
                end
                cmdSeen++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL global time limit: got expired, expected finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        int base;
        i_rst_n     = 1'b0;
        i_enable    = 1'b0;
        i_ch0_level = '0;
        i_ch1_level = '0;
        i_cmd_ready = 1'b1;
        i_bvalid    = 1'b0;
        i_bresp     = 2'b00;
        i_clr_err   = 1'b0;

        doReset();

        // Single ch0 burst and its one-cycle request-to-valid latency.
        expQ.push_back('{32'h1000_0000, 1'b0});
        applyStimulus(16, 0, 1'b1);
        @(negedge i_clk);
        checkOutput("valid one cycle after request", o_cmd_valid, 1);
        i_ch0_level = '0;
        @(negedge i_clk);
        checkOutput("ch0 ptr after first burst", o_ch0_ptr, 32'h1000_0080);
        checkOutput("outstanding after first burst", o_outstanding, 1);
        repeat (6) @(negedge i_clk);
        sendB(2'b00);
        checkOutput("outstanding after OKAY", o_outstanding, 0);
        repeat (2) @(negedge i_clk);
        checkOutput("busy when drained", o_busy, 0);

        // Alternating grants with ring wrap, stalling at four outstanding.
        doReset();
        base = cmdSeen;
        expQ.push_back('{32'h1000_0000, 1'b0});
        expQ.push_back('{32'h1800_0000, 1'b1});
        expQ.push_back('{32'h1000_0080, 1'b0});
        expQ.push_back('{32'h1800_0080, 1'b1});
        applyStimulus(32, 32, 1'b1);
        waitCmds(base + 4);
        repeat (20) @(negedge i_clk);
        checkOutput("stall at max outstanding", cmdSeen, base + 4);
        checkOutput("no valid while stalled", o_cmd_valid, 0);
        checkOutput("outstanding at max", o_outstanding, 4);
        checkOutput("ch0 ptr wrapped", o_ch0_ptr, 32'h1000_0000);
        checkOutput("ch1 ptr wrapped", o_ch1_ptr, 32'h1800_0000);
        expQ.push_back('{32'h1000_0000, 1'b0});
        sendB(2'b00);
        checkOutput("outstanding 4 to 3", o_outstanding, 3);
        waitCmds(base + 5);
        applyStimulus(0, 0, 1'b1);
        repeat (6) @(negedge i_clk);

        // Error response coinciding with a command handshake, held command while not ready.
        sendB(2'b00);
        checkOutput("outstanding before error test", o_outstanding, 3);
        i_cmd_ready = 1'b0;
        expQ.push_back('{32'h1800_0000, 1'b1});
        applyStimulus(0, 16, 1'b1);
        waitValid();
        repeat (3) @(negedge i_clk);
        checkOutput("valid held without ready", o_cmd_valid, 1);
        checkOutput("addr held without ready", o_cmd_addr, 32'h1800_0000);
        i_ch1_level = '0;
        i_cmd_ready = 1'b1;
        i_bvalid    = 1'b1;
        i_bresp     = 2'b10;
        @(negedge i_clk);
        i_bvalid = 1'b0;
        i_bresp  = 2'b00;
        checkOutput("outstanding unchanged on hs+B", o_outstanding, 3);
        checkOutput("err set by SLVERR", o_err, 1);
        repeat (6) @(negedge i_clk);
        @(negedge i_clk);
        i_bvalid  = 1'b1;
        i_bresp   = 2'b10;
        i_clr_err = 1'b1;
        @(negedge i_clk);
        i_bvalid  = 1'b0;
        i_bresp   = 2'b00;
        i_clr_err = 1'b0;
        checkOutput("err set wins over clear", o_err, 1);
        checkOutput("outstanding after error B", o_outstanding, 2);
        pulseClr();
        checkOutput("err cleared", o_err, 0);
        sendB(2'b00);
        sendB(2'b00);
        checkOutput("outstanding drained", o_outstanding, 0);
        sendB(2'b00);
        checkOutput("no underflow", o_outstanding, 0);
        checkOutput("err on stray B", o_err, 1);
        pulseClr();
        checkOutput("err cleared again", o_err, 0);

        // Level just below a burst, and scheduling disabled.
        base = cmdSeen;
        applyStimulus(15, 15, 1'b1);
        repeat (10) @(negedge i_clk);
        checkOutput("level 15 not eligible", cmdSeen, base);
        applyStimulus(32, 32, 1'b0);
        repeat (10) @(negedge i_clk);
        checkOutput("disabled issues nothing", cmdSeen, base);
        checkOutput("disabled valid low", o_cmd_valid, 0);

        // Reset asserted while the second burst is still in DATA.
        doReset();
        base = cmdSeen;
        expQ.push_back('{32'h1000_0000, 1'b0});
        expQ.push_back('{32'h1800_0000, 1'b1});
        applyStimulus(32, 32, 1'b1);
        waitCmds(base + 1);
        autoDone = 1'b0;
        waitCmds(base + 2);
        i_ch0_level = '0;
        i_ch1_level = '0;
        repeat (3) @(negedge i_clk);
        checkOutput("outstanding in DATA", o_outstanding, 2);
        checkOutput("busy in DATA", o_busy, 1);
        checkOutput("ch0 ptr before reset", o_ch0_ptr, 32'h1000_0080);
        checkOutput("ch1 ptr before reset", o_ch1_ptr, 32'h1800_0080);
`ifdef WR_SCHED_WATCHDOG_EN
        repeat (4000) @(negedge i_clk);
        checkOutput("no early timeout", o_timeout, 0);
        for (int i = 0; i < 200 && !o_timeout; i++) @(negedge i_clk);
        checkOutput("timeout raised", o_timeout, 1);
        checkOutput("outstanding kept on timeout", o_outstanding, 2);
        checkOutput("valid low after timeout", o_cmd_valid, 0);
`endif
        @(negedge i_clk);
        #1;
        i_rst_n = 1'b0;
        #1;
        checkOutput("mid reset cmd_valid", o_cmd_valid, 0);
        checkOutput("mid reset ch0_ptr", o_ch0_ptr, 32'h1000_0000);
        checkOutput("mid reset ch1_ptr", o_ch1_ptr, 32'h1800_0000);
        checkOutput("mid reset outstanding", o_outstanding, 0);
        checkOutput("mid reset busy", o_busy, 0);
        repeat (2) @(negedge i_clk);

        checkOutput("expected commands consumed", expQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
